// File: rtl/router_rx_port_if.sv
// router_rx_port_if: router output-FIFO read handshake plus the receiver's payload and status outputs.
interface router_rx_port_if;
  logic       valid_out;
  logic [7:0] data_out;
  logic       rx_ready;
  logic       read_enb;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic [5:0] hdr_len;
  logic [1:0] hdr_addr;
  logic       pkt_done;
  logic       parity_err;
  logic       addr_err;
  logic       pkt_abort;
  logic       busy_rx;
  modport master (
    output valid_out, data_out, rx_ready,
    input  read_enb, pl_data, pl_valid, hdr_len, hdr_addr, pkt_done, parity_err, addr_err, pkt_abort, busy_rx
  );
  modport slave (
    input  valid_out, data_out, rx_ready,
    output read_enb, pl_data, pl_valid, hdr_len, hdr_addr, pkt_done, parity_err, addr_err, pkt_abort, busy_rx
  );
endinterface

// File: rtl/router_rx_port.sv
// router_rx_port: drains one router output FIFO, forwards payload bytes and checks the trailing parity byte.
module router_rx_port #(
  parameter logic [1:0] PORT_ID = 2'd0,
  parameter int         TIMEOUT = 32
) (
  input logic             clock,
  input logic             reset,
  router_rx_port_if.slave rx
);
  typedef enum logic [2:0] {IDLE, HDR, HDR_CAP, BODY, DONE} state_t;
  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);
  state_t     state, state_nx;
  logic [6:0] rd_cnt, cap_cnt, tot;
  logic [7:0] idle_cnt, par;
  logic       rd, rd_pend, cap, cap_par, idle_inc, tmo;
  assign tot     = {1'b0, rx.hdr_len} + 7'd2;
  assign cap     = state == BODY && rd_pend;
  assign cap_par = cap && cap_cnt == tot - 7'd1;
  // an in-flight capture counts as progress, so it blocks the idle count as well as clearing it
  assign idle_inc    = (state == HDR || state == BODY) && !rx.valid_out && rx.rx_ready && !rd_pend;
  assign tmo         = idle_inc && idle_cnt == IDLE_LAST;
  assign rx.read_enb = rd && !reset;
  assign rx.busy_rx  = state != IDLE;
  always_comb begin
    rd = 1'b0;
    state_nx = state;
    if (state == IDLE) begin
      rd = rx.valid_out;
      state_nx = rd ? HDR : IDLE;
    end else if (state == HDR)
      state_nx = tmo ? IDLE : BODY;
    else if (state == BODY) begin
      rd = rx.valid_out && rx.rx_ready && rd_cnt < tot;
      state_nx = cap_par ? DONE : tmo ? IDLE : BODY;
    end else
      state_nx = IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state         <= IDLE;
      rd_cnt        <= '0;
      cap_cnt       <= '0;
      idle_cnt      <= '0;
      par           <= '0;
      rd_pend       <= 1'b0;
      rx.pl_data    <= '0;
      rx.pl_valid   <= 1'b0;
      rx.hdr_len    <= '0;
      rx.hdr_addr   <= '0;
      rx.pkt_done   <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.addr_err   <= 1'b0;
      rx.pkt_abort  <= 1'b0;
    end else begin
      state         <= state_nx;
      rd_pend       <= rd && state == BODY;
      idle_cnt      <= (state == IDLE || rd || rd_pend) ? '0 : idle_cnt + 8'(idle_inc);
      rx.pl_valid   <= cap && !cap_par;
      rx.pkt_done   <= cap_par;
      rx.parity_err <= cap_par && par != rx.data_out;
      rx.addr_err   <= cap_par && rx.hdr_addr != PORT_ID;
      rx.pkt_abort  <= tmo;
      if (state == HDR) begin
        {rx.hdr_len, rx.hdr_addr} <= rx.data_out;
        par     <= rx.data_out;
        rd_cnt  <= 7'd1;
        cap_cnt <= 7'd1;
      end
      if (state == BODY && rd) rd_cnt <= rd_cnt + 7'd1;
      if (cap) cap_cnt <= cap_cnt + 7'd1;
      if (cap && !cap_par) begin
        par        <= par ^ rx.data_out;
        rx.pl_data <= rx.data_out;
      end
    end
endmodule
